mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_mul_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Queues operand pairs for a 32-cycle sequential multiplier, issuing only on phase 0 and
// capturing the product one window later into a result FIFO. MUL_ISSUE_TAG_EN adds a 4-bit tag.
module mul_issue_ctrl #(
  parameter int DEPTH  = 4,
  parameter int RDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
`ifdef MUL_ISSUE_TAG_EN
  input  logic [3:0]  in_tag,
  output logic [3:0]  out_tag,
`endif
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_c
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RDEPTH);

  logic [4:0]    r_phase;
  logic [31:0]   r_a_mem [DEPTH];
  logic [31:0]   r_b_mem [DEPTH];
  logic [AW-1:0] r_op_wr, r_op_rd;
  logic [AW:0]   r_op_cnt;
  logic [63:0]   r_c_mem [RDEPTH];
  logic [RW-1:0] r_res_wr, r_res_rd;
  logic [RW:0]   r_res_cnt;
  logic          r_inflight;
  logic [31:0]   r_mul_a, r_mul_b;

  logic          w_phase0, w_push, w_issue, w_capture, w_pop;
  logic [RW:0]   w_occupied;

  assign w_phase0  = (r_phase == 5'd0);
  assign in_ready  = (r_op_cnt < (AW+1)'(DEPTH));
  assign out_valid = (r_res_cnt != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // At most one op is in the multiplier per window, so the inflight flag is the reservation count.
  assign w_occupied = r_res_cnt + {{RW{1'b0}}, r_inflight};
  assign w_issue   = w_phase0 && (r_op_cnt != '0) && (w_occupied < (RW+1)'(RDEPTH));
  assign w_capture = w_phase0 && r_inflight;

  assign mul_a = w_phase0 ? (w_issue ? r_a_mem[r_op_rd] : 32'd0) : r_mul_a;
  assign mul_b = w_phase0 ? (w_issue ? r_b_mem[r_op_rd] : 32'd0) : r_mul_b;
  assign out_c = out_valid ? r_c_mem[r_res_rd] : 64'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase    <= 5'd0;
      r_inflight <= 1'b0;
      r_mul_a    <= 32'd0;
      r_mul_b    <= 32'd0;
    end else begin
      r_phase <= r_phase + 5'd1;
      if (w_phase0) begin
        r_mul_a    <= mul_a;
        r_mul_b    <= mul_b;
        r_inflight <= w_issue;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_wr  <= '0;
      r_op_rd  <= '0;
      r_op_cnt <= '0;
    end else begin
      if (w_push)  r_op_wr <= r_op_wr + 1'b1;
      if (w_issue) r_op_rd <= r_op_rd + 1'b1;
      if (w_push && !w_issue)      r_op_cnt <= r_op_cnt + 1'b1;
      else if (!w_push && w_issue) r_op_cnt <= r_op_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_wr  <= '0;
      r_res_rd  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_capture) r_res_wr <= r_res_wr + 1'b1;
      if (w_pop)     r_res_rd <= r_res_rd + 1'b1;
      if (w_capture && !w_pop)      r_res_cnt <= r_res_cnt + 1'b1;
      else if (!w_capture && w_pop) r_res_cnt <= r_res_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_a_mem[r_op_wr] <= in_a;
      r_b_mem[r_op_wr] <= in_b;
    end
    if (w_capture) r_c_mem[r_res_wr] <= mul_c;
  end

`ifdef MUL_ISSUE_TAG_EN
  logic [3:0] r_t_mem  [DEPTH];
  logic [3:0] r_rt_mem [RDEPTH];
  logic [3:0] r_slot_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_slot_tag <= 4'd0;
    else if (w_issue) r_slot_tag <= r_t_mem[r_op_rd];
  end

  // The slot tag is read here before the same-cycle issue overwrites it.
  always_ff @(posedge clk) begin
    if (w_push)    r_t_mem[r_op_wr]   <= in_tag;
    if (w_capture) r_rt_mem[r_res_wr] <= r_slot_tag;
  end

  assign out_tag = out_valid ? r_rt_mem[r_res_rd] : 4'd0;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural 32-cycle multiplier sharing its reset.
// Results are collected by a monitor and compared against hand-computed products.
module tb_mul_issue_ctrl;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, mul_a, mul_b;
  logic [63:0] mul_c, out_c;
`ifdef MUL_ISSUE_TAG_EN
  logic [3:0]  in_tag, out_tag;
`endif

  mul_issue_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef MUL_ISSUE_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier: samples on the phase-0 edge, holds the product for the whole next window.
  logic [4:0] m_phase;
  int n_iss = 0;
  int last_iss_cyc = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 5'd0;
      mul_c   <= 64'd0;
    end else begin
      m_phase <= m_phase + 5'd1;
      if (m_phase == 5'd0) begin
        mul_c <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        if (mul_a != 32'd0) begin
          n_iss        <= n_iss + 1;
          last_iss_cyc <= cyc;
        end
      end
    end
  end

  logic [63:0] got_c[$];
  int          got_cyc[$];
  logic [3:0]  got_t[$];
  always begin
    @(negedge clk);
    #1;
    if (rst && out_valid && out_ready) begin
      got_c.push_back(out_c);
      got_cyc.push_back(cyc);
`ifdef MUL_ISSUE_TAG_EN
      got_t.push_back(out_tag);
`else
      got_t.push_back(4'd0);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] res_at(input int i);
    if (i < got_c.size()) return got_c[i];
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -1000;
  endfunction

  function automatic logic [3:0] tag_at(input int i);
    if (i < got_t.size()) return got_t[i];
    return 4'hF;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c",     out_c,     0);
    chk("rst_mul_a",     mul_a,     0);
    chk("rst_mul_b",     mul_b,     0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the pair was accepted.
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, input int budget);
    int w = 0;
    while (got_c.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("result_count", got_c.size(), n);
  endtask

  int base, iss0, bad, w;
  int bp_a[6] = '{2, 3, 4, 5, 6, 7};
  int bp_b[6] = '{-1, -2, -3, -4, -5, -6};
  longint bp_exp[6] = '{-2, -6, -12, -20, -30, -42};
  logic [63:0] b2b_exp[4] = '{64'd6, 64'd25, 64'd0, 64'hFFFF_FFFF_8000_0000};
  logic [63:0] held;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_a = 32'd0;
    in_b = 32'd0;
    out_ready = 1'b1;
`ifdef MUL_ISSUE_TAG_EN
    in_tag = 4'd0;
`endif

    // Single op: 7 x -3
    do_reset;
    base = got_c.size();
    push(32'd7, -32'sd3);
    wait_res(base + 1, 120);
    chk("single_c", res_at(base), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("single_latency", 64'(cyc_at(base) - last_iss_cyc), 64'd33);
    @(negedge clk);
    #1;
    chk("single_drained", out_valid, 0);

    // Back-to-back: four ops, one result per window, in order
    do_reset;
    base = got_c.size();
    push(32'd2, 32'd3);
    push(-32'sd5, -32'sd5);
    push(32'd0, 32'd9);
    push(32'h8000_0000, 32'd1);
    wait_res(base + 4, 4 * 32 + 80);
    for (int i = 0; i < 4; i++) chk("b2b_c", res_at(base + i), b2b_exp[i]);
    for (int i = 1; i < 4; i++)
      chk("b2b_spacing", 64'(cyc_at(base + i) - cyc_at(base + i - 1)), 64'd32);

    // Backpressure: result FIFO limits issues to two, operand FIFO fills
    do_reset;
    out_ready = 1'b0;
    base = got_c.size();
    iss0 = n_iss;
    for (int i = 0; i < 4; i++) push(bp_a[i], bp_b[i]);
    chk("bp_in_ready_full", in_ready, 0);
    push(bp_a[4], bp_b[4]);
    push(bp_a[5], bp_b[5]);
    repeat (70) @(negedge clk);
    chk("bp_issue_count", 64'(n_iss - iss0), 64'd2);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_in_ready_held", in_ready, 0);
    held = out_c;
    chk("bp_head", held, 64'(bp_exp[0]));
    repeat (5) @(negedge clk);
    chk("bp_head_stable", out_c, held);
    chk("bp_none_popped", got_c.size(), base);
    out_ready = 1'b1;
    wait_res(base + 6, 6 * 32 + 120);
    for (int i = 0; i < 6; i++) chk("bp_c", res_at(base + i), 64'(bp_exp[i]));

    // Idle slots: no input, multiplier sees zeros and nothing comes out
    do_reset;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (mul_a != 32'd0 || mul_b != 32'd0 || out_valid) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Reset during phase 17 with one result held and one op inflight
    do_reset;
    out_ready = 1'b0;
    push(32'd7, 32'd3);
    push(32'd5, 32'd5);
    w = 0;
    while (!out_valid && w < 120) begin
      @(negedge clk);
      w++;
    end
    chk("midop_pre_valid", out_valid, 1);
    w = 0;
    while (m_phase != 5'd17 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("midop_phase", m_phase, 17);
    chk("midop_pre_mul_a", mul_a, 5);
    rst = 1'b0;
    #1;
    chk("midop_out_valid", out_valid, 0);
    chk("midop_in_ready",  in_ready,  1);
    chk("midop_out_c",     out_c,     0);
    chk("midop_mul_a",     mul_a,     0);
    chk("midop_mul_b",     mul_b,     0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    base = got_c.size();
    repeat (100) @(negedge clk);
    chk("midop_no_stale", got_c.size(), base);

`ifdef MUL_ISSUE_TAG_EN
    // Tags travel with their operands
    do_reset;
    base = got_c.size();
    in_tag = 4'd3;
    push(32'd1, 32'd2);
    in_tag = 4'd9;
    push(32'd3, 32'd4);
    in_tag = 4'd12;
    push(32'd5, 32'd6);
    wait_res(base + 3, 3 * 32 + 100);
    chk("tag_c0", res_at(base), 64'd2);
    chk("tag_t0", tag_at(base), 4'd3);
    chk("tag_c1", res_at(base + 1), 64'd12);
    chk("tag_t1", tag_at(base + 1), 4'd9);
    chk("tag_c2", res_at(base + 2), 64'd30);
    chk("tag_t2", tag_at(base + 2), 4'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
